// File: rtl/vga_timing_gen.sv
// VGA timing generator: owns the column/row counters, decodes sync/DE/frame-start
// and delays that decode so it leaves on the same clock as the pattern video.
module vga_timing_gen #(
  parameter int unsigned COLOR_BITS    = 3,
  parameter int unsigned ACTIVE_COLS   = 640,
  parameter int unsigned FP_H          = 18,
  parameter int unsigned SYNC_H        = 92,
  parameter int unsigned BP_H          = 50,
  parameter int unsigned ACTIVE_ROWS   = 480,
  parameter int unsigned FP_V          = 10,
  parameter int unsigned SYNC_V        = 2,
  parameter int unsigned BP_V          = 33,
  parameter int unsigned HSYNC_POL     = 0,
  parameter int unsigned VSYNC_POL     = 0,
  parameter int unsigned VIDEO_LATENCY = 1,
  parameter int unsigned BLANK_VIDEO   = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Enable,
  output logic [9:0]            o_Col_Count,
  output logic [9:0]            o_Row_Count,
  input  logic [COLOR_BITS-1:0] i_Red_Video,
  input  logic [COLOR_BITS-1:0] i_Grn_Video,
  input  logic [COLOR_BITS-1:0] i_Blu_Video,
  output logic                  o_HSync,
  output logic                  o_VSync,
  output logic                  o_Active,
  output logic                  o_Frame_Start,
  output logic [COLOR_BITS-1:0] o_Red_Video,
  output logic [COLOR_BITS-1:0] o_Grn_Video,
  output logic [COLOR_BITS-1:0] o_Blu_Video
);

  localparam int unsigned TotalCols = ACTIVE_COLS + FP_H + SYNC_H + BP_H;
  localparam int unsigned TotalRows = ACTIVE_ROWS + FP_V + SYNC_V + BP_V;
  // Number of decode registers; the last one drives the pins.
  localparam int unsigned Lat       = VIDEO_LATENCY + 1;

  localparam logic [9:0] ColLast  = 10'(TotalCols - 1);
  localparam logic [9:0] RowLast  = 10'(TotalRows - 1);
  localparam logic [9:0] ActCols  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ActRows  = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HsFirst  = 10'(ACTIVE_COLS + FP_H);
  localparam logic [9:0] HsLast   = 10'(ACTIVE_COLS + FP_H + SYNC_H - 1);
  localparam logic [9:0] VsFirst  = 10'(ACTIVE_ROWS + FP_V);
  localparam logic [9:0] VsLast   = 10'(ACTIVE_ROWS + FP_V + SYNC_V - 1);
  localparam logic       HsOn     = (HSYNC_POL != 0);
  localparam logic       VsOn     = (VSYNC_POL != 0);

  // Timings outside what the 10-bit decode supports are refused at elaboration.
  if (TotalCols > 1024 || TotalRows > 1024) begin : gen_bad_total
    $error("vga_timing_gen: TOTAL_COLS/TOTAL_ROWS must not exceed 1024");
  end
  if (FP_H == 0 || FP_V == 0 || SYNC_H == 0 || SYNC_V == 0 || BP_H == 0 || BP_V == 0)
  begin : gen_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (VIDEO_LATENCY > 6) begin : gen_bad_latency
    $error("vga_timing_gen: VIDEO_LATENCY must be in 0..6");
  end

  logic [9:0]            col_q, col_d, row_q, row_d;
  logic [Lat-1:0]        hs_q, hs_d, vs_q, vs_d, act_q, act_d, fs_q, fs_d;
  logic [COLOR_BITS-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                  hs_lvl, vs_lvl, act, fs, blank;

  // Counter next-state: column wraps into a row increment, row wraps with it.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_Enable) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  // Decode of the current count, converted straight to pin levels for the syncs.
  always_comb begin
    hs_lvl = ((col_q >= HsFirst) && (col_q <= HsLast)) ? HsOn : ~HsOn;
    vs_lvl = ((row_q >= VsFirst) && (row_q <= VsLast)) ? VsOn : ~VsOn;
    act    = (col_q < ActCols) && (row_q < ActRows);
    fs     = (col_q == '0) && (row_q == '0) && i_Enable;
  end

  // Decode delay line plus the single video register; stage 0 takes the fresh decode.
  always_comb begin
    hs_d[0]  = hs_lvl;
    vs_d[0]  = vs_lvl;
    act_d[0] = act;
    fs_d[0]  = fs;
    for (int i = 1; i < Lat; i++) begin
      hs_d[i]  = hs_q[i-1];
      vs_d[i]  = vs_q[i-1];
      act_d[i] = act_q[i-1];
      fs_d[i]  = fs_q[i-1];
    end
    // act_d[Lat-1] is the DE that reaches o_Active on the same edge as this video.
    blank = (BLANK_VIDEO != 0) && !act_d[Lat-1];
    red_d = blank ? '0 : i_Red_Video;
    grn_d = blank ? '0 : i_Grn_Video;
    blu_d = blank ? '0 : i_Blu_Video;
  end

  // All state; reset clears every stage to its deasserted level.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q <= '0;
      row_q <= '0;
      hs_q  <= {Lat{~HsOn}};
      vs_q  <= {Lat{~VsOn}};
      act_q <= '0;
      fs_q  <= '0;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      fs_q  <= fs_d;
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_HSync       = hs_q[Lat-1];
  assign o_VSync       = vs_q[Lat-1];
  assign o_Active      = act_q[Lat-1];
  assign o_Frame_Start = fs_q[Lat-1];
  assign o_Red_Video   = red_q;
  assign o_Grn_Video   = grn_q;
  assign o_Blu_Video   = blu_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small timing so whole frames fit, randomized enable
// and video, reference model computes expected pins per screen position.
module tb_vga_timing_gen;

  localparam int unsigned CB  = 3;
  localparam int unsigned AC  = 16;
  localparam int unsigned FPH = 2;
  localparam int unsigned SH  = 3;
  localparam int unsigned BPH = 3;
  localparam int unsigned AR  = 8;
  localparam int unsigned FPV = 1;
  localparam int unsigned SV  = 2;
  localparam int unsigned BPV = 2;
  localparam int unsigned HP  = 0;
  localparam int unsigned VP  = 1;
  localparam int unsigned VL  = 3;
  localparam int unsigned TC  = AC + FPH + SH + BPH;
  localparam int unsigned TR  = AR + FPV + SV + BPV;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic [8:0] rgb;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          en = 1'b0;
  logic [9:0]    col, row;
  logic [CB-1:0] ri = '0, gi = '0, bi = '0;
  logic [CB-1:0] ro, go, bo;
  logic          hs, vs, act, fs;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   mcol = 0;
  int   mrow = 0;
  exp_t sb[$];
  logic [8:0] vq[$];
  exp_t mon_x;

  vga_timing_gen #(
    .COLOR_BITS   (CB),
    .ACTIVE_COLS  (AC),
    .FP_H         (FPH),
    .SYNC_H       (SH),
    .BP_H         (BPH),
    .ACTIVE_ROWS  (AR),
    .FP_V         (FPV),
    .SYNC_V       (SV),
    .BP_V         (BPV),
    .HSYNC_POL    (HP),
    .VSYNC_POL    (VP),
    .VIDEO_LATENCY(VL),
    .BLANK_VIDEO  (1)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Enable     (en),
    .o_Col_Count  (col),
    .o_Row_Count  (row),
    .i_Red_Video  (ri),
    .i_Grn_Video  (gi),
    .i_Blu_Video  (bi),
    .o_HSync      (hs),
    .o_VSync      (vs),
    .o_Active     (act),
    .o_Frame_Start(fs),
    .o_Red_Video  (ro),
    .o_Grn_Video  (go),
    .o_Blu_Video  (bo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, a, e, $time);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_col", 32'(col), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_hsync", 32'(hs), (HP == 0) ? 1 : 0);
    chk("rst_vsync", 32'(vs), (VP == 0) ? 1 : 0);
    chk("rst_active", 32'(act), 0);
    chk("rst_frame_start", 32'(fs), 0);
    chk("rst_video", 32'({ro, go, bo}), 0);
  endtask

  // Called at a negedge: checks live counts, drives video, pushes expected pins.
  task automatic step(input logic e);
    exp_t       x;
    logic [8:0] w;
    bit         in_h, in_v;
    chk("col_count", 32'(col), 32'(mcol));
    chk("row_count", 32'(row), 32'(mrow));
    en = e;
    w  = 9'($urandom);
    vq.push_back(w);
    if (vq.size() > VL) {ri, gi, bi} = vq.pop_front();
    in_h  = (mcol >= AC + FPH) && (mcol < AC + FPH + SH);
    in_v  = (mrow >= AR + FPV) && (mrow < AR + FPV + SV);
    x.hs  = (in_h == (HP != 0));
    x.vs  = (in_v == (VP != 0));
    x.act = (mcol < AC) && (mrow < AR);
    x.fs  = (mcol == 0) && (mrow == 0) && e;
    x.rgb = x.act ? w : 9'd0;
    sb.push_back(x);
    if (e) begin
      mcol = (mcol + 1) % TC;
      if (mcol == 0) mrow = (mrow + 1) % TR;
    end
  endtask

  // Monitor: an entry pushed before edge n is due after edge n+VL.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb.size() > VL + 1) begin
        checks++;
        errors++;
        $display("FAIL sb_depth: got %0d expected %0d", sb.size(), VL + 1);
        mon_x = sb.pop_front();
      end else if (sb.size() == VL + 1) begin
        mon_x = sb.pop_front();
        chk("hsync", 32'(hs), 32'(mon_x.hs));
        chk("vsync", 32'(vs), 32'(mon_x.vs));
        chk("active", 32'(act), 32'(mon_x.act));
        chk("frame_start", 32'(fs), 32'(mon_x.fs));
        chk("video", 32'({ro, go, bo}), 32'(mon_x.rgb));
      end
    end
  end

  task automatic restart_model();
    sb.delete();
    vq.delete();
    mcol = 0;
    mrow = 0;
  endtask

  initial begin
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state();

    @(negedge clk);
    rst_l  = 1'b1;
    mon_en = 1'b1;
    step(1'b1);
    // Two full frames with enable held high.
    repeat (2 * TC * TR) begin
      @(negedge clk);
      step(1'b1);
    end
    // Randomized enable.
    repeat (600) begin
      @(negedge clk);
      step($urandom_range(0, 3) != 0);
    end
    // Enable gap mid-line.
    while (mcol != 5) begin
      @(negedge clk);
      step(1'b1);
    end
    repeat (10) begin
      @(negedge clk);
      step(1'b0);
    end
    // Enable gap parked on (0,0): frame-start must stay low.
    while (!(mcol == 0 && mrow == 0)) begin
      @(negedge clk);
      step(1'b1);
    end
    repeat (4) begin
      @(negedge clk);
      step(1'b0);
    end
    repeat (40) begin
      @(negedge clk);
      step(1'b1);
    end
    // Asynchronous reset mid-frame, asserted between clock edges.
    while (mrow != 5) begin
      @(negedge clk);
      step(1'b1);
    end
    @(posedge clk);
    #2;
    rst_l  = 1'b0;
    mon_en = 1'b0;
    restart_model();
    #1;
    chk_reset_state();
    @(negedge clk);
    rst_l  = 1'b1;
    mon_en = 1'b1;
    step(1'b1);
    repeat (400) begin
      @(negedge clk);
      step($urandom_range(0, 4) != 0);
    end
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
